flasher_step_scheduler: RTL and testbench

//  Sequences the 16-LED bound flasher.
//  - Debounces the raw flick button and latches it as a pending request.
//  - Produces a programmable-rate single-cycle step strobe; the flasher

---
 rtl/flasher_step_scheduler_if.sv | 25 ++
 rtl/flasher_step_scheduler.sv | 125 ++++++++++++
 tb/tb_flasher_step_scheduler.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flasher_step_scheduler_if.sv
// Board-side bus of the flasher step scheduler: button, divider control,
// pause and LED feedback in; step strobe, flick request and status out.
interface flasher_step_scheduler_if #(
    parameter int DIV_W = 24
);
    logic             btn_raw;
    logic             div_load;
    logic [DIV_W-1:0] div_val;
    logic             pause;
    logic [15:0]      led_in;
    logic             step_en;
    logic             flick;
    logic [1:0]       state_o;
    logic             overrun;

    modport slave (
        input  btn_raw, div_load, div_val, pause, led_in,
        output step_en, flick, state_o, overrun
    );

    modport master (
        output btn_raw, div_load, div_val, pause, led_in,
        input  step_en, flick, state_o, overrun
    );
endinterface

// File: rtl/flasher_step_scheduler.sv
// Step scheduler for the 16-LED bound flasher: debounced flick latch,
// programmable step prescaler and IDLE/RUN/PAUSED sequencing.
module flasher_step_scheduler #(
    parameter int DIV_W       = 24,
    parameter int DIV_DEFAULT = 12_000_000,
    parameter int DEB_CYCLES  = 16,
    parameter int IDLE_STEPS  = 2
) (
    input  logic clk,
    input  logic rst_n,
    flasher_step_scheduler_if.slave bus
);
    localparam int DBW = $clog2(DEB_CYCLES + 1);
    localparam int ZW  = $clog2(IDLE_STEPS + 1);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_PAUSED = 2'b10
    } state_t;

    logic             r_sync1, r_sync2;
    logic             r_db, r_db_q;
    logic [DBW-1:0]   r_db_cnt;
    logic             r_pend, r_overrun;
    logic [DIV_W-1:0] r_div, r_cnt;
    logic [ZW-1:0]    r_zcnt;
    state_t           r_state;

    logic w_rise, w_term, w_step, w_zero, w_reach;

    assign w_rise  = r_db & ~r_db_q;
    assign w_term  = (r_cnt == r_div - DIV_W'(1));
    // A coincident load or pause wins over the terminal count.
    assign w_step  = (r_state == S_RUN) & w_term & ~bus.div_load & ~bus.pause;
    assign w_zero  = (bus.led_in == 16'h0000);
    assign w_reach = w_zero & (r_zcnt == ZW'(IDLE_STEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_db     <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= bus.btn_raw;
            r_sync2 <= r_sync1;
            // Count consecutive cycles the synced level disagrees with btn_db.
            if (r_sync2 != r_db) begin
                if (r_db_cnt == DBW'(DEB_CYCLES - 1)) begin
                    r_db     <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DBW'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_q    <= 1'b0;
            r_pend    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_db_q    <= r_db;
            r_overrun <= w_rise & r_pend & ~w_step;
            if (w_step)      r_pend <= w_rise;
            else if (w_rise) r_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= DIV_RST;
            r_cnt <= '0;
        end else if (bus.div_load) begin
            r_div <= (bus.div_val == '0) ? DIV_W'(1) : bus.div_val;
            r_cnt <= '0;
        end else if (r_state == S_RUN && !bus.pause) begin
            r_cnt <= w_term ? '0 : r_cnt + DIV_W'(1);
        end else if (r_state == S_IDLE) begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_zcnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_zcnt <= '0;
                    if (r_pend) r_state <= S_RUN;
                end
                S_RUN: begin
                    if (bus.pause) begin
                        r_state <= S_PAUSED;
                    end else if (w_step) begin
                        if (w_reach) begin
                            // A pending flick restarts the sequence instead of idling.
                            r_zcnt <= '0;
                            if (!r_pend) r_state <= S_IDLE;
                        end else begin
                            r_zcnt <= w_zero ? r_zcnt + ZW'(1) : '0;
                        end
                    end
                end
                S_PAUSED: begin
                    if (!bus.pause) r_state <= S_RUN;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.step_en = w_step;
    assign bus.flick   = r_pend;
    assign bus.state_o = r_state;
    assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_flasher_step_scheduler.sv
// Bench for flasher_step_scheduler: directed scenarios plus a random run
// against a cycle-level reference model of the scheduling rules.
module tb_flasher_step_scheduler;
    localparam int DIV_W = 24;
    localparam int DEB   = 16;
    localparam int IDLE_STEPS = 2;
    localparam int DIV_DEFAULT = 12_000_000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    flasher_step_scheduler_if #(.DIV_W(DIV_W)) bus ();

    flasher_step_scheduler #(
        .DIV_W(DIV_W), .DIV_DEFAULT(DIV_DEFAULT),
        .DEB_CYCLES(DEB), .IDLE_STEPS(IDLE_STEPS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    int unsigned m_div, m_cnt;
    int m_st, m_z;
    bit m_db, m_dbp, m_pend, m_ovr;
    bit m_h [0:DEB+1];

    task automatic model_reset();
        m_div = DIV_DEFAULT; m_cnt = 0; m_st = 0; m_z = 0;
        m_db = 0; m_dbp = 0; m_pend = 0; m_ovr = 0;
        for (int i = 0; i <= DEB + 1; i++) m_h[i] = 0;
    endtask

    function automatic bit exp_step();
        return (m_st == 1) && (m_cnt == m_div - 1) && !bus.div_load && !bus.pause;
    endfunction

    task automatic model_step();
        bit stp, rise, flip, npend, novr;
        int unsigned ndiv, ncnt;
        int nst, nz;
        if (!rst_n) begin model_reset(); return; end
        stp  = exp_step();
        rise = m_db && !m_dbp;
        // m_h[DEB+1] is the raw sample one edge back; the synchroniser hides it.
        flip = 1;
        for (int i = 1; i <= DEB; i++) if (m_h[i] == m_db) flip = 0;
        novr  = rise && m_pend && !stp;
        npend = stp ? rise : (m_pend || rise);
        ndiv = m_div; ncnt = m_cnt;
        if (bus.div_load) begin
            ndiv = (bus.div_val == 0) ? 1 : int'(bus.div_val);
            ncnt = 0;
        end else if (m_st == 1 && !bus.pause) ncnt = (m_cnt + 1) % m_div;
        else if (m_st == 0) ncnt = 0;
        nst = m_st; nz = m_z;
        case (m_st)
            0: begin nz = 0; if (m_pend) nst = 1; end
            1: if (bus.pause) nst = 2;
               else if (stp) begin
                   nz = (bus.led_in == 16'h0) ? m_z + 1 : 0;
                   if (nz >= IDLE_STEPS) begin nz = 0; if (!m_pend) nst = 0; end
               end
            default: if (!bus.pause) nst = 1;
        endcase
        for (int i = 0; i <= DEB; i++) m_h[i] = m_h[i+1];
        m_h[DEB+1] = bus.btn_raw;
        m_dbp = m_db; if (flip) m_db = !m_db;
        m_pend = npend; m_ovr = novr; m_div = ndiv; m_cnt = ncnt; m_st = nst; m_z = nz;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_div(input int v);
        bus.div_load = 1'b1; bus.div_val = DIV_W'(v);
        tick();
        bus.div_load = 1'b0;
    endtask

    task automatic press(input int hold);
        bus.btn_raw = 1'b1; ticks(hold);
        bus.btn_raw = 1'b0; ticks(22);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; model_reset();
        ticks(3);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.btn_raw = 0; bus.div_load = 0; bus.div_val = '0; bus.pause = 0; bus.led_in = 16'hFFFF;
        rst_n = 1'b0; model_reset();
        #2;
        n_vec++; if (bus.step_en !== 1'b0) begin n_err++; $display("FAIL rst_step: got %b want 0", bus.step_en); end
        n_vec++; if (bus.flick !== 1'b0) begin n_err++; $display("FAIL rst_flick: got %b want 0", bus.flick); end
        n_vec++; if (bus.state_o !== 2'b00) begin n_err++; $display("FAIL rst_state: got %b want 00", bus.state_o); end
        n_vec++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL rst_ovr: got %b want 0", bus.overrun); end
        ticks(2);
        rst_n = 1'b1;
        ticks(2);
    endtask

    task automatic test_debounce();
        bus.led_in = 16'hFFFF;
        load_div(4);
        bus.btn_raw = 1'b1; ticks(10); bus.btn_raw = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            n_vec++; if (bus.flick !== 1'b0) begin n_err++; $display("FAIL glitch_flick: got %b want 0 (cycle %0d)", bus.flick, k); end
        end
        bus.btn_raw = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 18) begin n_vec++; if (bus.flick !== 1'b0) begin n_err++; $display("FAIL deb_early: got %b want 0", bus.flick); end end
            if (k == 19) begin
                n_vec++; if (bus.flick !== 1'b1) begin n_err++; $display("FAIL deb_flick: got %b want 1", bus.flick); end
                n_vec++; if (bus.state_o !== 2'b00) begin n_err++; $display("FAIL deb_idle: got %b want 00", bus.state_o); end
            end
            if (k == 20) begin n_vec++; if (bus.state_o !== 2'b01) begin n_err++; $display("FAIL deb_run: got %b want 01", bus.state_o); end end
            if (k == 22) begin n_vec++; if (bus.step_en !== 1'b0) begin n_err++; $display("FAIL deb_nostep: got %b want 0", bus.step_en); end end
            if (k == 23) begin n_vec++; if (bus.step_en !== 1'b1) begin n_err++; $display("FAIL deb_step: got %b want 1", bus.step_en); end end
            if (k == 24) begin
                n_vec++; if (bus.step_en !== 1'b0) begin n_err++; $display("FAIL deb_step1: got %b want 0", bus.step_en); end
                n_vec++; if (bus.flick !== 1'b0) begin n_err++; $display("FAIL deb_consume: got %b want 0", bus.flick); end
            end
        end
        bus.btn_raw = 1'b0; ticks(22);
    endtask

    task automatic test_sequence_end();
        logic [15:0] pat [4] = '{16'h0000, 16'h0001, 16'h0000, 16'h0000};
        logic [1:0]  est [4] = '{2'b01, 2'b01, 2'b01, 2'b00};
        int idx = 0;
        for (int c = 0; c < 60 && idx < 4; c++) begin
            bus.led_in = pat[idx];
            #1;
            if (exp_step()) begin
                tick();
                n_vec++; if (bus.state_o !== est[idx]) begin n_err++; $display("FAIL seq_state%0d: got %b want %b", idx, bus.state_o, est[idx]); end
                idx++;
            end else tick();
        end
        n_vec++; if (idx !== 4) begin n_err++; $display("FAIL seq_steps: got %0d want 4", idx); end
        for (int c = 0; c < 20; c++) begin
            tick();
            n_vec++; if (bus.step_en !== 1'b0 || bus.state_o !== 2'b00) begin
                n_err++; $display("FAIL seq_idle: got step %b state %b want 0 00", bus.step_en, bus.state_o); end
        end
    endtask

    task automatic test_overrun();
        int pulses = 0;
        bus.led_in = 16'hFFFF;
        load_div(1000);
        press(20);
        n_vec++; if (bus.state_o !== 2'b01 || bus.flick !== 1'b1) begin
            n_err++; $display("FAIL ovr_pre: got state %b flick %b want 01 1", bus.state_o, bus.flick); end
        bus.btn_raw = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            pulses += int'(bus.overrun);
            if (k == 18) begin n_vec++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL ovr_early: got %b want 0", bus.overrun); end end
            if (k == 19) begin
                n_vec++; if (bus.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_pulse: got %b want 1", bus.overrun); end
                n_vec++; if (bus.flick !== 1'b1) begin n_err++; $display("FAIL ovr_flick: got %b want 1", bus.flick); end
            end
        end
        n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL ovr_count: got %0d want 1", pulses); end
        bus.btn_raw = 1'b0; ticks(22);
        // Align the terminal count with the cycle in which the new edge is detected.
        bus.btn_raw = 1'b1; ticks(10);
        load_div(8);
        ticks(7);
        n_vec++; if (bus.step_en !== 1'b1) begin n_err++; $display("FAIL coin_step: got %b want 1", bus.step_en); end
        tick();
        n_vec++; if (bus.flick !== 1'b1 || bus.overrun !== 1'b0) begin
            n_err++; $display("FAIL coin_flick: got flick %b ovr %b want 1 0", bus.flick, bus.overrun); end
        ticks(8);
        n_vec++; if (bus.flick !== 1'b0) begin n_err++; $display("FAIL coin_consume: got %b want 0", bus.flick); end
        bus.btn_raw = 1'b0; ticks(22);
    endtask

    task automatic test_pause();
        bus.led_in = 16'hFFFF;
        load_div(8);
        ticks(5);
        bus.pause = 1'b1; #1;
        n_vec++; if (bus.step_en !== 1'b0) begin n_err++; $display("FAIL pause_nostep: got %b want 0", bus.step_en); end
        tick();
        n_vec++; if (bus.state_o !== 2'b10) begin n_err++; $display("FAIL pause_state: got %b want 10", bus.state_o); end
        for (int k = 0; k < 19; k++) begin
            tick();
            n_vec++; if (bus.step_en !== 1'b0 || bus.state_o !== 2'b10) begin
                n_err++; $display("FAIL pause_hold: got step %b state %b want 0 10", bus.step_en, bus.state_o); end
        end
        bus.pause = 1'b0;
        tick();
        n_vec++; if (bus.state_o !== 2'b01) begin n_err++; $display("FAIL resume_state: got %b want 01", bus.state_o); end
        tick();
        n_vec++; if (bus.step_en !== 1'b0) begin n_err++; $display("FAIL resume_early: got %b want 0", bus.step_en); end
        tick();
        n_vec++; if (bus.step_en !== 1'b1) begin n_err++; $display("FAIL resume_step: got %b want 1", bus.step_en); end
    endtask

    task automatic test_divider();
        bus.div_load = 1'b1; bus.div_val = '0; #1;
        n_vec++; if (bus.step_en !== 1'b0) begin n_err++; $display("FAIL div0_supp: got %b want 0", bus.step_en); end
        tick();
        bus.div_load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_vec++; if (bus.step_en !== 1'b1) begin n_err++; $display("FAIL div0_every: got %b want 1 (cycle %0d)", bus.step_en, k); end
            tick();
        end
        load_div(4);
        ticks(3);
        n_vec++; if (bus.step_en !== 1'b1) begin n_err++; $display("FAIL div4_term: got %b want 1", bus.step_en); end
        bus.div_load = 1'b1; bus.div_val = DIV_W'(4); #1;
        n_vec++; if (bus.step_en !== 1'b0) begin n_err++; $display("FAIL ld_term_supp: got %b want 0", bus.step_en); end
        tick();
        bus.div_load = 1'b0;
        ticks(2);
        n_vec++; if (bus.step_en !== 1'b0) begin n_err++; $display("FAIL ld_term_cnt: got %b want 0", bus.step_en); end
        tick();
        n_vec++; if (bus.step_en !== 1'b1) begin n_err++; $display("FAIL ld_term_step: got %b want 1", bus.step_en); end
    endtask

    task automatic test_random();
        do_reset();
        bus.btn_raw = 0; bus.pause = 0; bus.div_load = 0;
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(24, 0) == 0) bus.btn_raw = ~bus.btn_raw;
            if ($urandom_range(39, 0) == 0) bus.pause = ~bus.pause;
            bus.div_load = ($urandom_range(149, 0) == 0);
            bus.div_val  = DIV_W'($urandom_range(6, 0));
            bus.led_in   = ($urandom_range(2, 0) == 0) ? 16'h0 : 16'($urandom);
            #1;
            n_vec++; if (bus.step_en !== exp_step()) begin n_err++; $display("FAIL rnd_step@%0d: got %b want %b", c, bus.step_en, exp_step()); end
            n_vec++; if (bus.flick !== m_pend) begin n_err++; $display("FAIL rnd_flick@%0d: got %b want %b", c, bus.flick, m_pend); end
            n_vec++; if (bus.state_o !== 2'(m_st)) begin n_err++; $display("FAIL rnd_state@%0d: got %b want %0d", c, bus.state_o, m_st); end
            n_vec++; if (bus.overrun !== m_ovr) begin n_err++; $display("FAIL rnd_ovr@%0d: got %b want %b", c, bus.overrun, m_ovr); end
            tick();
        end
        bus.btn_raw = 0; bus.pause = 0; bus.div_load = 0;
    endtask

    task automatic test_abort();
        do_reset();
        bus.led_in = 16'hFFFF;
        load_div(1);
        press(20);
        n_vec++; if (bus.step_en !== 1'b1 || bus.state_o !== 2'b01) begin
            n_err++; $display("FAIL abort_pre: got step %b state %b want 1 01", bus.step_en, bus.state_o); end
        rst_n = 1'b0; model_reset(); #1;
        n_vec++; if (bus.step_en !== 1'b0) begin n_err++; $display("FAIL abort_step: got %b want 0", bus.step_en); end
        n_vec++; if (bus.flick !== 1'b0) begin n_err++; $display("FAIL abort_flick: got %b want 0", bus.flick); end
        n_vec++; if (bus.state_o !== 2'b00) begin n_err++; $display("FAIL abort_state: got %b want 00", bus.state_o); end
        tick();
        rst_n = 1'b1;
        ticks(3);
        n_vec++; if (bus.state_o !== 2'b00 || bus.step_en !== 1'b0) begin
            n_err++; $display("FAIL abort_after: got state %b step %b want 00 0", bus.state_o, bus.step_en); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_sequence_end();
        test_overrun();
        test_pause();
        test_divider();
        test_random();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
